key_note_player: RTL
====================

Name: key_note_player

Overview:
- Sequencing controller between the PS/2 scan-code receiver and the speaker pin.
- Consumes the scan-code byte stream and tracks make/break (0xF0) and extended (0xE0) prefixes to keep one currently held note.
- Looks up the note's half period through the key-to-note lookup.
- Generates a square wave on the speaker output for as long as that key is held (monophonic, last-key-wins).

Parameters:
- PRESCALE, 50, clock cycles per half-period unit (1 us at 50 MHz); legal range >= 1.
- HP_WIDTH, 21, width of the half-period value returned by the lookup.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- scan_code  in  8  received PS/2 byte
- scan_valid  in  1  one-cycle strobe; scan_code is valid this cycle
- speaker  out  1  square-wave tone output
- playing  out  1  high while a note is held
- active_key  out  8  scan code of the held note; 0x00 when silent

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values: speaker=0, playing=0, active_key=0x00, held half period=0, prescaler=0, period counter=0, FSM=IDLE.
- Reset asserted mid-note silences the output on the next edge.
- Lookup:
  - The lookup sub-module is driven combinationally by scan_code.
  - It returns 0 for every unmapped code. Mapped codes are 0x15,1D,24,2D,2C,35,3C,43,44,4D,54,5B.
- FSM, evaluated only on cycles with scan_valid=1:
  - IDLE:
    - 0xF0 -> BRK.
    - 0xE0 -> EXT.
    - Mapped code, different from active_key -> latch active_key=code and half period=lookup; playing=1; clear prescaler, period counter and speaker. Stay IDLE.
    - Mapped code equal to active_key (typematic repeat) -> no change. Phase is continuous.
    - Unmapped code -> ignored.
  - BRK:
    - Any code -> IDLE.
    - If code==active_key -> playing=0, active_key=0x00, speaker=0, counters cleared.
    - Otherwise the break is ignored and the held note continues.
  - EXT:
    - 0xF0 -> EXT_BRK.
    - Any other code -> IDLE; the byte is discarded.
  - EXT_BRK:
    - Any code -> IDLE; the byte is discarded.
- All state updates are registered. playing and active_key change on the edge that samples the scan_valid byte (one-cycle latency).
- Tone generation, only while playing=1:
  - Prescaler counts 0..PRESCALE-1 and emits a tick when it wraps.
  - The period counter advances on each tick.
  - On a tick with counter==half_period-1: speaker toggles and the counter returns to 0.
  - First speaker rise comes PRESCALE*half_period cycles after the note-start edge. The full tone period is 2*PRESCALE*half_period cycles.
- While playing=0: prescaler and counter are held at 0 and speaker=0.
- Key change while playing: the new note starts from phase 0 the same cycle it is latched. No glitch pulse is allowed: speaker is forced to 0 on that edge.
- A scan_valid that is high on consecutive cycles is processed byte by byte.

Decomposition:
- Package key_note_pkg holds:
  - Scan-code localparams KEY_Q..KEY_CLOSE_BRACE, BREAK_CODE=0xF0 and EXT_CODE=0xE0.
  - The FSM state encoding (IDLE, BRK, EXT, EXT_BRK).
  - HP_WIDTH.
- One sub-module: the existing key-to-note lookup (data -> half_period), instantiated once.
- Tone counter logic stays inline.

Test Plan:
- Reset, PRESCALE=2; send 0x15 (Q) -> next cycle playing=1, active_key=0x15; speaker rises exactly 2*HP(0x15) cycles later; measured period is 4*HP(0x15).
- While Q is held, send 0x15 again five times -> no counter restart; speaker edge timing unchanged.
- Q held; send 0x2C (T) -> active_key=0x2C, speaker=0 on that edge; next rise 2*HP(0x2C) later. Then send F0,15 -> still playing T. Then send F0,2C -> playing=0, active_key=0x00, speaker=0.
- IDLE; send E0,15 and E0,F0,15 -> no note starts. Then send 0x15 -> plays, confirming a return to IDLE.
- Send 0x1C (unmapped) -> no change. Send F0 alone, then 0x15 -> treated as a break; nothing plays.
- Q playing with speaker=1; assert reset for 1 cycle -> all outputs 0 the next cycle. Send 0x24 after reset -> clean start with phase 0.

Source files
------------

// File: rtl/key_note_pkg.sv
// Shared scan codes, FSM encoding and half-period width for the key-to-tone player.
package key_note_pkg;

  localparam int HP_WIDTH = 21;

  localparam logic [7:0] KEY_Q           = 8'h15;
  localparam logic [7:0] KEY_W           = 8'h1D;
  localparam logic [7:0] KEY_E           = 8'h24;
  localparam logic [7:0] KEY_R           = 8'h2D;
  localparam logic [7:0] KEY_T           = 8'h2C;
  localparam logic [7:0] KEY_Y           = 8'h35;
  localparam logic [7:0] KEY_U           = 8'h3C;
  localparam logic [7:0] KEY_I           = 8'h43;
  localparam logic [7:0] KEY_O           = 8'h44;
  localparam logic [7:0] KEY_P           = 8'h4D;
  localparam logic [7:0] KEY_OPEN_BRACE  = 8'h54;
  localparam logic [7:0] KEY_CLOSE_BRACE = 8'h5B;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } state_e;

endpackage

// File: rtl/key_note_lookup.sv
// Key-to-note lookup: scan code to tone half period in microseconds, C4..G5; 0 = unmapped.
module key_note_lookup
  import key_note_pkg::*;
(
  input  logic [7:0]          data,
  output logic [HP_WIDTH-1:0] half_period
);

  always_comb begin
    half_period = '0;
    case (data)
      KEY_Q:           half_period = HP_WIDTH'(1911);
      KEY_W:           half_period = HP_WIDTH'(1703);
      KEY_E:           half_period = HP_WIDTH'(1517);
      KEY_R:           half_period = HP_WIDTH'(1432);
      KEY_T:           half_period = HP_WIDTH'(1276);
      KEY_Y:           half_period = HP_WIDTH'(1136);
      KEY_U:           half_period = HP_WIDTH'(1012);
      KEY_I:           half_period = HP_WIDTH'(956);
      KEY_O:           half_period = HP_WIDTH'(851);
      KEY_P:           half_period = HP_WIDTH'(758);
      KEY_OPEN_BRACE:  half_period = HP_WIDTH'(716);
      KEY_CLOSE_BRACE: half_period = HP_WIDTH'(638);
      default:         half_period = '0;
    endcase
  end

endmodule

// File: rtl/key_note_player.sv
// Monophonic, last-key-wins tone player: tracks PS/2 make/break/extended prefixes
// and drives a square wave on speaker while the latched key is held.
module key_note_player
  import key_note_pkg::*;
#(
  parameter int PRESCALE = 50,
  parameter int HP_WIDTH = key_note_pkg::HP_WIDTH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic       speaker,
  output logic       playing,
  output logic [7:0] active_key
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  state_e              state, state_nxt;
  logic [HP_WIDTH-1:0] lookup_hp;
  logic [HP_WIDTH-1:0] half_period;
  logic [HP_WIDTH-1:0] period_cnt;
  logic [PS_W-1:0]     prescaler;
  logic                start_note;
  logic                stop_note;
  logic                tick;

  key_note_lookup u_lookup (
    .data        (scan_code),
    .half_period (lookup_hp)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (scan_valid) begin
      case (state)
        IDLE: begin
          if (scan_code == BREAK_CODE)    state_nxt = BRK;
          else if (scan_code == EXT_CODE) state_nxt = EXT;
          else                            state_nxt = IDLE;
        end
        BRK:     state_nxt = IDLE;
        EXT:     state_nxt = (scan_code == BREAK_CODE) ? EXT_BRK : IDLE;
        EXT_BRK: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Prefix bytes are unmapped, so a nonzero lookup alone marks a playable key.
  always_comb begin
    start_note = 1'b0;
    stop_note  = 1'b0;
    if (scan_valid) begin
      case (state)
        IDLE:    start_note = (lookup_hp != '0) && (scan_code != active_key);
        BRK:     stop_note  = (scan_code == active_key);
        default: ;
      endcase
    end
  end

  assign tick = (prescaler == PS_W'(PRESCALE - 1));

  // Tone stage: a key change restarts from phase 0 with speaker forced low.
  always_ff @(posedge clk) begin
    if (reset) begin
      playing     <= 1'b0;
      active_key  <= 8'h00;
      half_period <= '0;
      prescaler   <= '0;
      period_cnt  <= '0;
      speaker     <= 1'b0;
    end else if (start_note) begin
      playing     <= 1'b1;
      active_key  <= scan_code;
      half_period <= lookup_hp;
      prescaler   <= '0;
      period_cnt  <= '0;
      speaker     <= 1'b0;
    end else if (stop_note) begin
      playing     <= 1'b0;
      active_key  <= 8'h00;
      half_period <= '0;
      prescaler   <= '0;
      period_cnt  <= '0;
      speaker     <= 1'b0;
    end else if (playing) begin
      prescaler <= tick ? '0 : prescaler + PS_W'(1);
      if (tick) begin
        if (period_cnt == half_period - HP_WIDTH'(1)) begin
          period_cnt <= '0;
          speaker    <= ~speaker;
        end else begin
          period_cnt <= period_cnt + HP_WIDTH'(1);
        end
      end
    end else begin
      prescaler  <= '0;
      period_cnt <= '0;
      speaker    <= 1'b0;
    end
  end

endmodule
